// File: rtl/adder_resp_checker.sv
`default_nettype none
// ============================================================================
// Module      : adder_resp_checker
// Description : On-board response analyser for adder equivalence sweeps.
//               Cross-compares a reference adder against a DUT adder over an
//               exhaustive sweep of 2^(2*WIDTH+1) vectors, counts vectors and
//               mismatches, and captures the first failing vector.
//               Optional macro CHECKER_GOLDEN_EN adds an internal golden adder
//               that also checks both results against a + b + cin.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_resp_checker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 2*WIDTH+2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic [WIDTH-1:0] s_ref_i,
  input  logic             cout_ref_i,
  input  logic [WIDTH-1:0] s_dut_i,
  input  logic             cout_dut_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] vec_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             fail_valid_o,
  output logic [WIDTH-1:0] fail_a_o,
  output logic [WIDTH-1:0] fail_b_o,
  output logic             fail_cin_o,
  output logic             golden_mm_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Count value held just before the final accept of a full sweep.
  localparam logic [CNT_W-1:0] C_LAST_CNT = (CNT_W'(1) << (2*WIDTH+1)) - CNT_W'(1);
  localparam logic [CNT_W-1:0] C_ERR_MAX  = '1;

  state_t           state_q,      state_d;
  logic [CNT_W-1:0] vec_cnt_q,    vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q,    err_cnt_d;
  logic             fail_valid_q, fail_valid_d;
  logic [WIDTH-1:0] fail_a_q,     fail_a_d;
  logic [WIDTH-1:0] fail_b_q,     fail_b_d;
  logic             fail_cin_q,   fail_cin_d;
  logic             pass_q,       pass_d;
  logic             golden_mm_q,  golden_mm_d;

  logic w_accept;
  logic w_cross_mm;
  logic w_mismatch;
  logic w_ref_golden_mm;

  assign w_accept   = (state_q == ST_RUN) && in_valid_i;
  assign w_cross_mm = ({cout_ref_i, s_ref_i} != {cout_dut_i, s_dut_i});

`ifdef CHECKER_GOLDEN_EN
  // Golden sum at WIDTH+1 bits so the carry lines up with {cout, s}.
  logic [WIDTH:0] w_golden;
  logic           w_dut_golden_mm;

  assign w_golden        = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
  assign w_dut_golden_mm = ({cout_dut_i, s_dut_i} != w_golden);
  assign w_ref_golden_mm = ({cout_ref_i, s_ref_i} != w_golden);
  assign w_mismatch      = w_cross_mm | w_dut_golden_mm;
`else
  // Cross-compare only; the golden flag can never set.
  assign w_ref_golden_mm = 1'b0;
  assign w_mismatch      = w_cross_mm;
`endif

  // Next-state and datapath update: start clears the sweep, accepts count.
  always_comb begin
    state_d      = state_q;
    vec_cnt_d    = vec_cnt_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    fail_a_d     = fail_a_q;
    fail_b_d     = fail_b_q;
    fail_cin_d   = fail_cin_q;
    pass_d       = pass_q;
    golden_mm_d  = golden_mm_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Start has priority over any bundle presented in the same cycle.
        if (start_i) begin
          state_d      = ST_RUN;
          vec_cnt_d    = '0;
          err_cnt_d    = '0;
          fail_valid_d = 1'b0;
          fail_a_d     = '0;
          fail_b_d     = '0;
          fail_cin_d   = 1'b0;
          pass_d       = 1'b0;
          golden_mm_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          vec_cnt_d = vec_cnt_q + CNT_W'(1);
          if (w_mismatch) begin
            if (err_cnt_q != C_ERR_MAX) begin
              err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            // Only the first failing vector of a sweep is kept.
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_a_d     = a_i;
              fail_b_d     = b_i;
              fail_cin_d   = cin_i;
            end
          end
          if (w_ref_golden_mm) begin
            golden_mm_d = 1'b1;
          end
          // Verdict is registered alongside the move to DONE.
          if (vec_cnt_q == C_LAST_CNT) begin
            state_d = ST_DONE;
            pass_d  = (err_cnt_d == '0);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vec_cnt_q    <= '0;
      err_cnt_q    <= '0;
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_cin_q   <= 1'b0;
      pass_q       <= 1'b0;
      golden_mm_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_cnt_q    <= vec_cnt_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      fail_a_q     <= fail_a_d;
      fail_b_q     <= fail_b_d;
      fail_cin_q   <= fail_cin_d;
      pass_q       <= pass_d;
      golden_mm_q  <= golden_mm_d;
    end
  end

  assign busy_o       = (state_q == ST_RUN);
  assign done_o       = (state_q == ST_DONE);
  assign pass_o       = pass_q;
  assign vec_cnt_o    = vec_cnt_q;
  assign err_cnt_o    = err_cnt_q;
  assign fail_valid_o = fail_valid_q;
  assign fail_a_o     = fail_a_q;
  assign fail_b_o     = fail_b_q;
  assign fail_cin_o   = fail_cin_q;
  assign golden_mm_o  = golden_mm_q;

endmodule
`default_nettype wire
